// File: rtl/gold_nic.sv
// Network interface between a PE and the ring router PE port: one outbound and one inbound
// single-entry packet buffer, register-mapped on the PE side, send/ready on the router side.
module gold_nic #(
   parameter int unsigned PACKET_SIZE = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             addr,
   input  logic [PACKET_SIZE-1:0] d_in,
   output logic [PACKET_SIZE-1:0] d_out,
   input  logic                   nicEn,
   input  logic                   nicWrEn,
   input  logic                   polarity,
   output logic                   net_so,
   input  logic                   net_ro,
   output logic [PACKET_SIZE-1:0] net_do,
   input  logic                   net_si,
   output logic                   net_ri,
   input  logic [PACKET_SIZE-1:0] net_di
);

   localparam logic [1:0] AddrInBuf     = 2'b00;
   localparam logic [1:0] AddrInStatus  = 2'b01;
   localparam logic [1:0] AddrOutBuf    = 2'b10;
   localparam logic [1:0] AddrOutStatus = 2'b11;

   localparam int unsigned VcBit = PACKET_SIZE - 1;

   logic [PACKET_SIZE-1:0] obuf_q, obuf_d;
   logic                   ob_full_q, ob_full_d;
   logic [PACKET_SIZE-1:0] ibuf_q, ibuf_d;
   logic                   ib_full_q, ib_full_d;
   logic [PACKET_SIZE-1:0] d_out_q, d_out_d;

   logic pe_wr;
   logic pe_rd;
   logic ob_wr;
   logic ob_xfer;
   logic ib_accept;
   logic ib_rd;

   assign pe_wr = nicEn & nicWrEn;
   assign pe_rd = nicEn & ~nicWrEn;

   // A write to a full buffer is dropped even if the buffer drains at this same edge.
   assign ob_wr   = pe_wr & (addr == AddrOutBuf) & ~ob_full_q;
   assign ob_xfer = net_so & net_ro;

   assign ib_accept = net_si & ~ib_full_q;
   assign ib_rd     = pe_rd & (addr == AddrInBuf);

   // Only inject when the packet VC matches the router's current external VC.
   assign net_so = ob_full_q & (obuf_q[VcBit] == polarity);
   assign net_do = obuf_q;
   assign net_ri = ~ib_full_q;
   assign d_out  = d_out_q;

   always_comb begin
      obuf_d    = obuf_q;
      ob_full_d = ob_full_q;
      if (ob_wr) begin
         obuf_d    = d_in;
         ob_full_d = 1'b1;
      end else if (ob_xfer) begin
         ob_full_d = 1'b0;
      end
   end

   always_comb begin
      ibuf_d    = ibuf_q;
      ib_full_d = ib_full_q;
      if (ib_accept) begin
         ibuf_d    = net_di;
         ib_full_d = 1'b1;
      end else if (ib_rd) begin
         ib_full_d = 1'b0;
      end
   end

   always_comb begin
      d_out_d = d_out_q;
      if (pe_rd) begin
         unique case (addr)
            AddrInBuf:     d_out_d = ibuf_q;
            AddrInStatus:  d_out_d = {{(PACKET_SIZE-1){1'b0}}, ib_full_q};
            AddrOutBuf:    d_out_d = '0;
            AddrOutStatus: d_out_d = {{(PACKET_SIZE-1){1'b0}}, ob_full_q};
            default:       d_out_d = d_out_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         obuf_q    <= '0;
         ob_full_q <= 1'b0;
         ibuf_q    <= '0;
         ib_full_q <= 1'b0;
         d_out_q   <= '0;
      end else begin
         obuf_q    <= obuf_d;
         ob_full_q <= ob_full_d;
         ibuf_q    <= ibuf_d;
         ib_full_q <= ib_full_d;
         d_out_q   <= d_out_d;
      end
   end

endmodule

// File: tb/tb_gold_nic.sv
// Scoreboard bench for gold_nic: expected router transfers and PE read results are queued
// when stimulus is driven and compared when the DUT produces them.
module tb_gold_nic;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  addr = 2'b00;
   logic [63:0] d_in = '0;
   logic [63:0] d_out;
   logic        nicEn = 1'b0;
   logic        nicWrEn = 1'b0;
   logic        polarity = 1'b0;
   logic        net_so;
   logic        net_ro = 1'b0;
   logic [63:0] net_do;
   logic        net_si = 1'b0;
   logic        net_ri;
   logic [63:0] net_di = '0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] exp_tx[$];
   logic [63:0] exp_rd[$];

   gold_nic #(.PACKET_SIZE(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .d_in     (d_in),
      .d_out    (d_out),
      .nicEn    (nicEn),
      .nicWrEn  (nicWrEn),
      .polarity (polarity),
      .net_so   (net_so),
      .net_ro   (net_ro),
      .net_do   (net_do),
      .net_si   (net_si),
      .net_ri   (net_ri),
      .net_di   (net_di)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pe_write(input logic [1:0] a, input logic [63:0] data);
      addr    = a;
      d_in    = data;
      nicEn   = 1'b1;
      nicWrEn = 1'b1;
      step();
      nicEn   = 1'b0;
      nicWrEn = 1'b0;
   endtask

   task automatic pe_read(input string tag, input logic [1:0] a, input logic [63:0] exp);
      addr    = a;
      nicEn   = 1'b1;
      nicWrEn = 1'b0;
      exp_rd.push_back(exp);
      step();
      nicEn = 1'b0;
      check_eq(tag, d_out, exp_rd.pop_front());
   endtask

   // Router-side monitor: a transfer happens at the coming edge when send and ready are both high.
   always @(negedge clk) begin
      if (reset && net_so && net_ro) begin
         if (exp_tx.size() == 0) check_eq("tx_unexpected", net_do, 64'hx);
         else                    check_eq("tx_pkt", net_do, exp_tx.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1 reset
      repeat (3) @(posedge clk);
      #3;
      check_eq("rst_dout", d_out, 64'h0);
      check_eq("rst_so", {63'b0, net_so}, 64'h0);
      check_eq("rst_ri", {63'b0, net_ri}, 64'h1);
      check_eq("rst_do", net_do, 64'h0);
      reset = 1'b1;
      step();
      pe_read("rst_st01", 2'b01, 64'h0);
      pe_read("rst_st11", 2'b11, 64'h0);

      // 2 inject
      polarity = 1'b0;
      net_ro   = 1'b1;
      exp_tx.push_back(64'h0000_0000_1234_5678);
      pe_write(2'b10, 64'h0000_0000_1234_5678);
      check_eq("inj_so", {63'b0, net_so}, 64'h1);
      check_eq("inj_do", net_do, 64'h0000_0000_1234_5678);
      step();
      pe_read("inj_st11", 2'b11, 64'h0);

      // 3 polarity gate
      exp_tx.push_back(64'h8000_0000_0000_00AA);
      pe_write(2'b10, 64'h8000_0000_0000_00AA);
      check_eq("gate_so0", {63'b0, net_so}, 64'h0);
      step();
      step();
      check_eq("gate_so1", {63'b0, net_so}, 64'h0);
      polarity = 1'b1;
      #1;
      check_eq("gate_so_pol", {63'b0, net_so}, 64'h1);
      step();
      polarity = 1'b0;
      check_eq("gate_so_done", {63'b0, net_so}, 64'h0);
      pe_read("gate_st11", 2'b11, 64'h0);

      // 4 back-pressure and dropped writes
      net_ro = 1'b0;
      exp_tx.push_back(64'h1);
      pe_write(2'b10, 64'h1);
      pe_write(2'b10, 64'h2);
      check_eq("bp_do", net_do, 64'h1);
      pe_read("bp_st11", 2'b11, 64'h1);
      check_eq("bp_do2", net_do, 64'h1);
      // Drain and write in the same cycle: the write must still be dropped.
      net_ro = 1'b1;
      pe_write(2'b10, 64'h3);
      check_eq("bp_so_empty", {63'b0, net_so}, 64'h0);
      pe_read("bp_st11_after", 2'b11, 64'h0);
      step();
      check_eq("bp_so_idle", {63'b0, net_so}, 64'h0);

      // 5 receive
      net_si = 1'b1;
      net_di = 64'hDEAD_BEEF_CAFE_F00D;
      step();
      check_eq("rx_ri0", {63'b0, net_ri}, 64'h0);
      net_di = 64'h0123_4567_89AB_CDEF;
      step();
      check_eq("rx_ri_hold", {63'b0, net_ri}, 64'h0);
      pe_read("rx_st01", 2'b01, 64'h1);
      pe_read("rx_data1", 2'b00, 64'hDEAD_BEEF_CAFE_F00D);
      check_eq("rx_ri1", {63'b0, net_ri}, 64'h1);
      step();
      net_si = 1'b0;
      check_eq("rx_ri_second", {63'b0, net_ri}, 64'h0);
      pe_read("rx_data2", 2'b00, 64'h0123_4567_89AB_CDEF);
      check_eq("rx_ri2", {63'b0, net_ri}, 64'h1);
      addr = 2'b01;
      step();
      check_eq("rd_hold", d_out, 64'h0123_4567_89AB_CDEF);
      pe_read("rx_stale", 2'b00, 64'h0123_4567_89AB_CDEF);
      check_eq("rx_stale_ri", {63'b0, net_ri}, 64'h1);
      pe_write(2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
      pe_write(2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
      pe_read("wr_ign_st01", 2'b01, 64'h0);
      pe_read("wr_ign_st11", 2'b11, 64'h0);
      pe_read("wr_ign_ibuf", 2'b00, 64'h0123_4567_89AB_CDEF);
      pe_read("rd_obuf_zero", 2'b10, 64'h0);

      // 6 async reset with both buffers full (queued packet is aborted, never expected)
      net_ro = 1'b0;
      pe_write(2'b10, 64'h0000_0000_0000_0055);
      net_si = 1'b1;
      net_di = 64'h5555_AAAA_5555_AAAA;
      step();
      net_si = 1'b0;
      check_eq("ar_pre_so", {63'b0, net_so}, 64'h1);
      check_eq("ar_pre_ri", {63'b0, net_ri}, 64'h0);
      #2;
      reset = 1'b0;
      #1;
      check_eq("ar_so", {63'b0, net_so}, 64'h0);
      check_eq("ar_ri", {63'b0, net_ri}, 64'h1);
      check_eq("ar_dout", d_out, 64'h0);
      check_eq("ar_do", net_do, 64'h0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      net_ro = 1'b1;
      step();
      pe_read("ar_st01", 2'b01, 64'h0);
      pe_read("ar_st11", 2'b11, 64'h0);
      check_eq("ar_so_after", {63'b0, net_so}, 64'h0);

      step();
      check_eq("tx_leftover", 64'(exp_tx.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
